cdc_msg_serializer: RTL
=======================

// Module: cdc_msg_serializer
// PURPOSE
//  Upstream feeder for the 4-phase CDC source half. Splits one wide message into NUM_BEATS narrow beats.
//  The CDC data bus and its max_delay-constrained async paths stay BEAT_W(+1) wide, not message wide.
//  Output is valid/ready and drives the CDC src_data_i/src_valid_i/src_ready_o directly.
//  Beat tag out_last_o travels with each beat so the far side can reassemble.
// PARAMETERS
//  BEAT_W     8  width of one output beat, >=1
//  NUM_BEATS  4  beats per message, >=1; message width MSG_W = BEAT_W*NUM_BEATS
//  MSB_FIRST  0  0: beat 0 = msg[BEAT_W-1:0]; 1: beat 0 = msg[MSG_W-1 -: BEAT_W]
// PORTS
//  clk_i        in   1       single clock
//  rst_i        in   1       asynchronous, active-high reset
//  msg_data_i   in   MSG_W   message to send
//  msg_valid_i  in   1       message valid
//  msg_ready_o  out  1       message accepted when msg_valid_i & msg_ready_o
//  out_data_o   out  BEAT_W  current beat
//  out_last_o   out  1       current beat is the final beat of its message
//  out_valid_o  out  1       beat valid
//  out_ready_i  in   1       beat consumed when out_valid_o & out_ready_i
//  busy_o       out  1       message in flight (state SEND)
// BEHAVIOUR
//  Reset (async, while rst_i=1) clears the following:
//   - state=IDLE, beat_cnt=0, shift reg=0
//   - out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0
//   - msg_ready_o is forced 0 while rst_i=1; it is 1 from the first cycle after release.
//  FSM IDLE:
//   - msg_ready_o=1.
//   - On msg handshake: load shift reg, beat_cnt=0, ->SEND.
//   - out_valid_o=1 from the next cycle (1-cycle accept-to-beat latency).
//  FSM SEND:
//   - out_valid_o=1; out_data_o is the current beat from the shift reg.
//   - out_last_o = (beat_cnt==NUM_BEATS-1).
//   - Beat handshake, not last: shift by BEAT_W (direction per MSB_FIRST), beat_cnt++.
//   - Beat handshake on last beat: ->IDLE unless a new msg is accepted in the same cycle.
//  Back-to-back:
//   - msg_ready_o = IDLE | (out_valid_o & out_ready_i & out_last_o); combinational ready path.
//   - A msg handshake on the last-beat handshake reloads the shift reg, beat_cnt=0, stays SEND.
//   - Zero bubble between messages.
//  Stability:
//   - While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o are held constant.
//   - out_valid_o never drops without a handshake, except on reset.
//   - Required: the CDC src samples on valid.
//  Outputs are registered (out_*, busy_o) and glitch-free into the async channel.
//  beat_cnt width: $clog2(NUM_BEATS), min 1. Wrap is never reached; the counter reloads to 0 on the last beat.
//  NUM_BEATS==1: every beat has out_last_o=1; the block degenerates to a 1-entry register slice.
//  Reset mid-message: the partial message is dropped with no resumption.
//   - Downstream sees out_valid_o fall asynchronously.
//   - System-level rule: assert rst_i together with the CDC src reset.
//  msg_valid_i during SEND (not last-beat handshake): ignored; msg_ready_o=0; the input must hold.
//  out_ready_i while out_valid_o=0: no effect.
// STRUCTURE
//  Shared package cdc_pkg:
//   - typedef enum logic {SER_IDLE, SER_SEND} ser_state_e
//   - function cnt_w(n) returning max(1,$clog2(n))
//  Single module; no sub-module.
//   - Shift reg + counter + 2-state FSM are inline.
//   - Pairing with the CDC pair is done in a separate top-level wrapper, not here.
// TESTING  (BEAT_W=8, NUM_BEATS=4 unless noted)
//  1. Basic send:
//     - Stimulus: msg 0xDDCCBBAA, MSB_FIRST=0, out_ready_i=1.
//     - Response: beats AA,BB,CC,DD on consecutive cycles, starting 1 cycle after accept; last=1 only on DD.
//  2. MSB_FIRST=1, same msg:
//     - Response: beats DD,CC,BB,AA.
//     - Random out_ready_i stalls: data/last stable during stalls; exactly 4 handshakes.
//  3. Back-to-back:
//     - Stimulus: msgs 0x04030201 then 0x08070605 presented continuously.
//     - Response: 8 beats 01..08 in 8 consecutive cycles; msg_ready_o high only on the DD-equivalent beat.
//  4. Reset mid-message:
//     - Stimulus: rst_i asserted after beat 2 handshake.
//     - Response: out_valid_o=0 immediately; busy_o=0.
//     - After release, msg 0x11223344 sends 44,33,22,11 (or 44 first per MSB_FIRST=0) with no stale beats.
//  5. NUM_BEATS=1, BEAT_W=16:
//     - Stimulus: msgs 0xBEEF, 0xCAFE with out_ready_i=1.
//     - Response: each beat last=1; 1 msg/cycle sustained.
//  6. Hold check:
//     - Stimulus: msg_valid_i=1 with new data during SEND, not last beat.
//     - Response: msg_ready_o=0; in-flight beats unchanged.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the CDC message path.
package cdc_pkg;

  typedef enum logic {SER_IDLE = 1'b0, SER_SEND = 1'b1} ser_state_e;

  function automatic int cnt_w(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/cdc_msg_serializer.sv
// Splits one wide message into NUM_BEATS narrow valid/ready beats tagged with a
// last flag, feeding the source half of a 4-phase CDC channel.
module cdc_msg_serializer
  import cdc_pkg::*;
#(
  parameter int BEAT_W    = 8,
  parameter int NUM_BEATS = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BEAT_W*NUM_BEATS-1:0]   msg_data_i,
  input  logic                          msg_valid_i,
  output logic                          msg_ready_o,
  output logic [BEAT_W-1:0]             out_data_o,
  output logic                          out_last_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);

  localparam int MSG_W = BEAT_W * NUM_BEATS;
  localparam int CW    = cnt_w(NUM_BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BEATS - 1);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic             last_q, last_d;
  logic             in_send;
  logic             beat_hs;
  logic             msg_hs;

  assign in_send = (state_q == SER_SEND);
  assign beat_hs = in_send & out_ready_i;
  assign cnt_inc = cnt_q + CW'(1);

  // Ready is combinational so a new message can ride on the last-beat handshake.
  assign msg_ready_o = ~rst_i & (~in_send | (beat_hs & last_q));
  assign msg_hs      = msg_valid_i & msg_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    last_d  = last_q;
    if (msg_hs) begin
      state_d = SER_SEND;
      cnt_d   = '0;
      shift_d = msg_data_i;
      last_d  = (LAST_CNT == '0);
    end else if (beat_hs) begin
      if (last_q) begin
        state_d = SER_IDLE;
        cnt_d   = '0;
        last_d  = 1'b0;
      end else begin
        cnt_d   = cnt_inc;
        last_d  = (cnt_inc == LAST_CNT);
        shift_d = (MSB_FIRST != 0) ? (shift_q << BEAT_W) : (shift_q >> BEAT_W);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      last_q  <= last_d;
    end
  end

  // The beat is a fixed slice of the shift register, so it comes straight off flops.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign out_data_o = shift_q[MSG_W-1 -: BEAT_W];
    end else begin : g_lsb
      assign out_data_o = shift_q[BEAT_W-1:0];
    end
  endgenerate

  assign out_valid_o = in_send;
  assign out_last_o  = last_q;
  assign busy_o      = in_send;

endmodule
